spi_master_multi: RTL
=====================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
Parameters:
REQ-001 SHALL provide parameter NUM_CS, default 2, meaning number of active-low slave selects (1..8).
REQ-002 SHALL provide parameter DIV_WIDTH, default 8, meaning width of the SCLK half-period divider register (1..8).
REQ-003 SHALL provide parameter RESET_DIV, default 8'hFF, meaning divider value after reset (slow SD-init clock), truncated to DIV_WIDTH.

Ports:
REQ-004 SHALL provide E  input  1  system clock; all state updates on falling edge of E.
REQ-005 SHALL provide RESET  input  1  synchronous, active-high reset, sampled on falling edge of E.
REQ-006 SHALL provide SEL  input  1  register block selected (address decode done externally).
REQ-007 SHALL provide RnW  input  1  CPU read (1) / write (0).
REQ-008 SHALL provide ADDR  input  2  register select.
REQ-009 SHALL provide DATA_in  input  8  CPU write data.
REQ-010 SHALL provide DATA_out  output  8  CPU read data.
REQ-011 SHALL provide DATA_oe  output  1  equals E & RnW & SEL.
REQ-012 SHALL provide SCLK  output  1  SPI clock.
REQ-013 SHALL provide MOSI  output  1  SPI data out.
REQ-014 SHALL provide MISO  input  1  SPI data in.
REQ-015 SHALL provide SS_n  output  NUM_CS  slave selects, active low.
REQ-016 SHALL provide IRQ  output  1  DONE & IE.

Function
REQ-017 Register map SHALL be: 0 DATA (W: tx byte, starts transfer; R: last rx byte); 1 CTRL (R/W bit0 CPHA, bit1 CPOL, bit2 LSBF, bit3 IE; R-only bit5 OVR, bit6 DONE, bit7 BUSY); 2 DIV; 3 SS (bit n=1 drives SS_n[n] low; bits ≥NUM_CS read 0).
REQ-018 A write SHALL be a falling E edge with SEL=1, RnW=0; a read access is a falling E edge with SEL=1, RnW=1.
REQ-019 A write to DATA while BUSY=0 SHALL load the shift register, set BUSY, and clear DONE on that edge.
REQ-020 A write to DATA while BUSY=1 SHALL be ignored apart from setting OVR.
REQ-021 Writes to CTRL bits 0-2 and to DIV while BUSY=1 SHALL be ignored; IE and SS writes SHALL always take effect.
REQ-022 A transfer SHALL be exactly 16 half-periods, each DIV+1 E cycles, so BUSY=1 for exactly 16*(DIV+1) E cycles.
REQ-023 SCLK SHALL equal CPOL when idle and toggle at the end of each of the first 15 half-periods; it returns to CPOL when BUSY clears.
REQ-024 MOSI bit order SHALL be MSB first when LSBF=0 and LSB first when LSBF=1; MISO bits fill the receive register in the same order.
REQ-025 With CPHA=0, the first bit SHALL be on MOSI from the start edge; MISO SHALL be sampled at each leading SCLK edge; MOSI SHALL advance at each trailing edge.
REQ-026 With CPHA=1, MOSI SHALL advance at each leading edge, and MISO SHALL be sampled at each trailing edge.
REQ-027 When idle, MOSI SHALL be 1.
REQ-028 On the final edge of the transfer, BUSY SHALL clear, DONE SHALL set, and the rx byte SHALL be readable at DATA.
REQ-029 A DATA write on the same edge BUSY clears SHALL be treated as busy (ignored, OVR set).
REQ-030 A read of DATA SHALL clear DONE; a read of CTRL SHALL clear OVR; the read value SHALL be the pre-clear value.
REQ-031 Divider counter SHALL wrap from DIV to 0.
REQ-032 With DIV=0, SCLK SHALL toggle every E cycle.
REQ-033 Read mux: ADDR 0 returns rx byte; ADDR 1 returns CTRL; ADDR 2 returns DIV zero-extended; ADDR 3 returns SS.

Reset
REQ-034 RESET=1 at a falling E edge SHALL abort any transfer.
REQ-035 After reset, register values SHALL be: CTRL=0, DIV=RESET_DIV, SS=0, rx=0, BUSY=DONE=OVR=0.
REQ-036 After reset, outputs SHALL be: SCLK=0, MOSI=1, SS_n=all 1, IRQ=0.

Verification
REQ-037 Scenario (mode 0, MSBF): DIV=1, CTRL=0, write DATA=A5, MISO loops MOSI -> BUSY 32 cycles, 8 SCLK pulses, MOSI 1,0,1,0,0,1,0,1, rx=A5, DONE=1.
REQ-038 Scenario (mode 3, LSBF): DIV=0, CTRL=07, write 3C, MISO tied 1 -> SCLK idles 1, 16 cycles busy, MOSI 0,0,1,1,1,1,0,0, rx=FF.
REQ-039 Scenario (overrun): write DATA=11, then DATA=22 mid-transfer -> only 11 shifted, CTRL reads 0xA0 during busy then OVR cleared on next read.
REQ-040 Scenario (IRQ and DIV): IE=1, transfer complete -> IRQ=1 until DATA read; DIV write during busy leaves DIV unchanged.
REQ-041 Scenario (reset mid-transfer): RESET after 5 cycles -> next edge SCLK=0, MOSI=1, BUSY=0, DIV=FF, SS_n=all 1.
REQ-042 Scenario (selects): NUM_CS=2, write SS=FF -> SS reads 03, SS_n=00.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with CPU register block (DATA/CTRL/DIV/SS), all four SPI modes,
// selectable bit order, programmable SCLK divider and up to eight slave selects.
module spi_master_multi #(
    parameter int         NUM_CS    = 2,
    parameter int         DIV_WIDTH = 8,
    parameter logic [7:0] RESET_DIV = 8'hFF
) (
    input  logic              E,
    input  logic              RESET,
    input  logic              SEL,
    input  logic              RnW,
    input  logic [1:0]        ADDR,
    input  logic [7:0]        DATA_in,
    output logic [7:0]        DATA_out,
    output logic              DATA_oe,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_CS-1:0] SS_n,
    output logic              IRQ
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                 state_reg;
    logic                   cpha_reg, cpol_reg, lsbf_reg, ie_reg;
    logic                   ovr_reg, done_reg;
    logic [DIV_WIDTH-1:0]   div_reg, div_cnt_reg;
    logic [NUM_CS-1:0]      ss_reg;
    logic [7:0]             tx_reg, rx_shift_reg, rx_reg;
    logic [3:0]             hp_cnt_reg;
    logic                   sclk_reg, mosi_reg;

    logic                   busy, wr_en, rd_en, hp_end, sample_evt;
    logic [2:0]             tx_n, tx_idx, rx_idx;
    logic [7:0]             rx_sampled, ctrl_rd, div_rd, ss_rd;

    assign busy  = (state_reg == ST_BUSY);
    assign wr_en = SEL & ~RnW;
    assign rd_en = SEL & RnW;

    // hp_cnt_reg counts completed half-periods; even count => next edge is leading.
    assign hp_end     = busy && (div_cnt_reg == div_reg);
    assign sample_evt = hp_end && (hp_cnt_reg[0] == cpha_reg);
    assign tx_n       = 3'((hp_cnt_reg + 4'd1) >> 1);
    assign tx_idx     = lsbf_reg ? tx_n : 3'd7 - tx_n;
    assign rx_idx     = lsbf_reg ? hp_cnt_reg[3:1] : 3'd7 - hp_cnt_reg[3:1];

    always_comb begin
        rx_sampled         = rx_shift_reg;
        rx_sampled[rx_idx] = MISO;
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd_ext
            if (gi < DIV_WIDTH) begin : g_div
                assign div_rd[gi] = div_reg[gi];
            end else begin : g_div_pad
                assign div_rd[gi] = 1'b0;
            end
            if (gi < NUM_CS) begin : g_ss
                assign ss_rd[gi] = ss_reg[gi];
            end else begin : g_ss_pad
                assign ss_rd[gi] = 1'b0;
            end
        end
    endgenerate

    assign ctrl_rd = {busy, done_reg, ovr_reg, 1'b0, ie_reg, lsbf_reg, cpol_reg, cpha_reg};

    always_comb begin
        DATA_out = rx_reg;
        case (ADDR)
            2'd0:    DATA_out = rx_reg;
            2'd1:    DATA_out = ctrl_rd;
            2'd2:    DATA_out = div_rd;
            default: DATA_out = ss_rd;
        endcase
    end

    assign DATA_oe = E & RnW & SEL;
    assign SCLK    = sclk_reg;
    assign MOSI    = mosi_reg;
    assign SS_n    = ~ss_reg;
    assign IRQ     = done_reg & ie_reg;

    always_ff @(negedge E) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            cpha_reg     <= 1'b0;
            cpol_reg     <= 1'b0;
            lsbf_reg     <= 1'b0;
            ie_reg       <= 1'b0;
            ovr_reg      <= 1'b0;
            done_reg     <= 1'b0;
            div_reg      <= RESET_DIV[DIV_WIDTH-1:0];
            div_cnt_reg  <= '0;
            ss_reg       <= '0;
            tx_reg       <= 8'h00;
            rx_shift_reg <= 8'h00;
            rx_reg       <= 8'h00;
            hp_cnt_reg   <= 4'd0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
        end else begin
            if (rd_en && ADDR == 2'd0) done_reg <= 1'b0;
            if (rd_en && ADDR == 2'd1) ovr_reg  <= 1'b0;

            if (wr_en) begin
                case (ADDR)
                    2'd0: begin
                        if (busy) begin
                            ovr_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_BUSY;
                            tx_reg      <= DATA_in;
                            done_reg    <= 1'b0;
                            div_cnt_reg <= '0;
                            hp_cnt_reg  <= 4'd0;
                            // CPHA=1 presents the first bit only at the first leading edge
                            mosi_reg    <= cpha_reg ? 1'b1 : DATA_in[lsbf_reg ? 0 : 7];
                        end
                    end
                    2'd1: begin
                        ie_reg <= DATA_in[3];
                        if (!busy) begin
                            cpha_reg <= DATA_in[0];
                            cpol_reg <= DATA_in[1];
                            lsbf_reg <= DATA_in[2];
                            sclk_reg <= DATA_in[1];
                        end
                    end
                    2'd2: if (!busy) div_reg <= DATA_in[DIV_WIDTH-1:0];
                    default: ss_reg <= DATA_in[NUM_CS-1:0];
                endcase
            end

            if (busy) begin
                if (hp_end) begin
                    div_cnt_reg <= '0;
                    hp_cnt_reg  <= hp_cnt_reg + 4'd1;
                    if (sample_evt) rx_shift_reg <= rx_sampled;
                    if (hp_cnt_reg == 4'd15) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                        sclk_reg  <= cpol_reg;
                        mosi_reg  <= 1'b1;
                        rx_reg    <= sample_evt ? rx_sampled : rx_shift_reg;
                    end else begin
                        sclk_reg <= ~sclk_reg;
                        if (!sample_evt) mosi_reg <= tx_reg[tx_idx];
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule
